// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_pkg
//  Description : Shared types and encodings for the multi-cycle MIPS control.
//  Revision    : 1.0
// ============================================================================
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_EXC      = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    IC_R, IC_I, IC_LOAD, IC_STORE, IC_BRANCH, IC_JUMP, IC_JR, IC_BAD
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_LUI = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS    = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SEXT    = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_write;
    logic       reg_dst;
    logic       mem2reg;
    logic       reg_jal;
    logic       retire;
  } ctrl_t;

  function automatic iclass_e classify(input logic [5:0] op, input logic [5:0] fn);
    iclass_e c;
    c = IC_BAD;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SRL: c = IC_R;
          FN_JR:                                         c = IC_JR;
          default:                                       c = IC_BAD;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: c = IC_I;
      OP_LW:                                     c = IC_LOAD;
      OP_SW:                                     c = IC_STORE;
      OP_BEQ, OP_BNE:                            c = IC_BRANCH;
      OP_J, OP_JAL:                              c = IC_JUMP;
      default:                                   c = IC_BAD;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] alu_op(input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] a;
    a = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_SUB:  a = ALU_SUB;
        FN_AND:  a = ALU_AND;
        FN_OR:   a = ALU_OR;
        FN_SLT:  a = ALU_SLT;
        FN_SRL:  a = ALU_SRL;
        default: a = ALU_ADD;
      endcase
    end else begin
      case (op)
        OP_SLTI: a = ALU_SLT;
        OP_ANDI: a = ALU_AND;
        OP_ORI:  a = ALU_OR;
        OP_LUI:  a = ALU_LUI;
        default: a = ALU_ADD;
      endcase
    end
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_decode
//  Description : State -> datapath control decode. CTRL_EXC_EN suppresses the
//                NOP retire for unsupported encodings.
//  Revision    : 1.0
// ============================================================================
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  input  logic       zero_i,
  input  logic       mem_ack_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.alu_src_a = SRCA_PC;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_ack_i;
        ctrl_o.pc_write  = mem_ack_i;
        ctrl_o.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        // Speculative branch target lands in ALUOut for a possible BRANCH.
        ctrl_o.alu_src_a = SRCA_PC;
        ctrl_o.alu_src_b = SRCB_SEXT_SH;
`ifndef CTRL_EXC_EN
        ctrl_o.retire    = (classify(opcode_i, func_i) == IC_BAD);
`endif
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a   = (func_i == FN_SRL) ? SRCA_SHAMT : SRCA_RS;
        ctrl_o.alu_src_b   = SRCB_RT;
        ctrl_o.alu_control = alu_op(opcode_i, func_i);
      end
      S_WB_R: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a   = SRCA_RS;
        ctrl_o.alu_src_b   = SRCB_SEXT;
        ctrl_o.alu_control = alu_op(opcode_i, func_i);
      end
      S_WB_I: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = SRCA_RS;
        ctrl_o.alu_src_b = SRCB_SEXT;
      end
      S_MEM_RD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mem2reg   = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.mem_we  = 1'b1;
        ctrl_o.iord    = 1'b1;
        ctrl_o.retire  = mem_ack_i;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a   = SRCA_RS;
        ctrl_o.alu_src_b   = SRCB_RT;
        ctrl_o.alu_control = ALU_SUB;
        ctrl_o.pc_src      = PCSRC_ALUOUT;
        ctrl_o.pc_write    = (opcode_i == OP_BEQ) ? zero_i : ~zero_i;
        ctrl_o.retire      = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_src    = PCSRC_JUMP;
        ctrl_o.reg_write = (opcode_i == OP_JAL);
        ctrl_o.reg_jal   = (opcode_i == OP_JAL);
        ctrl_o.retire    = 1'b1;
      end
      S_JR: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PCSRC_RS;
        ctrl_o.retire   = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control
//  Description : Multi-cycle MIPS control FSM with memory req/ack handshake and
//                retired-instruction counter. CTRL_EXC_EN adds exception state.
//  Revision    : 1.0
// ============================================================================
module mc_control
  import mc_pkg::*;
#(
  parameter int ALUCTRL_W   = 3,
  parameter int RETIRE_W    = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 zero,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem2reg,
  output logic                 reg_jal,
  output logic                 retire,
  output logic [RETIRE_W-1:0]  retired_cnt,
  output logic                 exc
);

  state_e              state_q, state_d;
  ctrl_t               dec_ctrl, ctrl;
  iclass_e             iclass;
  logic                tmo_expire;
  logic [RETIRE_W-1:0] retired_cnt_q;

  mc_ctrl_decode u_decode (
    .state_i   (state_q),
    .opcode_i  (opcode),
    .func_i    (func),
    .zero_i    (zero),
    .mem_ack_i (mem_ack),
    .ctrl_o    (dec_ctrl)
  );

  // Reset forces every strobe low in the same cycle, including mem_req.
  assign ctrl   = reset ? '0 : dec_ctrl;
  assign iclass = classify(opcode, func);

`ifdef CTRL_EXC_EN
  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [TMO_W-1:0] tmo_q;
  logic             exc_q;

  assign tmo_expire = ctrl.mem_req && !mem_ack && (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
      exc_q <= 1'b0;
    end else begin
      if (ctrl.mem_req && !mem_ack && !tmo_expire)
        tmo_q <= tmo_q + TMO_W'(1);
      else
        tmo_q <= '0;
      if (state_d == S_EXC)
        exc_q <= 1'b1;
    end
  end

  assign exc = exc_q & ~reset;
`else
  // Memory never times out; the comparison is constant false.
  assign tmo_expire = (MEM_TIMEOUT < 0);
  assign exc        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack)         state_d = S_DECODE;
        else if (tmo_expire) state_d = S_EXC;
      end
      S_DECODE: begin
        case (iclass)
          IC_R:               state_d = S_EXEC_R;
          IC_I:               state_d = S_EXEC_I;
          IC_LOAD, IC_STORE:  state_d = S_MEM_ADDR;
          IC_BRANCH:          state_d = S_BRANCH;
          IC_JUMP:            state_d = S_JUMP;
          IC_JR:              state_d = S_JR;
          default: begin
`ifdef CTRL_EXC_EN
            state_d = S_EXC;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (iclass == IC_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ack)         state_d = S_MEM_WB;
        else if (tmo_expire) state_d = S_EXC;
      end
      S_MEM_WR: begin
        if (mem_ack)         state_d = S_FETCH;
        else if (tmo_expire) state_d = S_EXC;
      end
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
      S_EXC:   state_d = S_EXC;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      retired_cnt_q <= retired_cnt_q + RETIRE_W'(ctrl.retire);
    end
  end

  assign mem_req     = ctrl.mem_req;
  assign mem_we      = ctrl.mem_we;
  assign iord        = ctrl.iord;
  assign ir_write    = ctrl.ir_write;
  assign pc_write    = ctrl.pc_write;
  assign pc_src      = ctrl.pc_src;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_control = ALUCTRL_W'(ctrl.alu_control);
  assign reg_write   = ctrl.reg_write;
  assign reg_dst     = ctrl.reg_dst;
  assign mem2reg     = ctrl.mem2reg;
  assign reg_jal     = ctrl.reg_jal;
  assign retire      = ctrl.retire;
  assign retired_cnt = retired_cnt_q;

endmodule
`default_nettype wire
